// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: runtime frame configuration and FSM state encoding.
package uart_rx_pkg;

    localparam int DIV_W_C = 16;

    // Field ordering mirrors tx_config_t so one config word can drive both ends of a link.
    typedef struct packed {
        logic [DIV_W_C-1:0] br_div;
        logic               word;
        logic               stop;
    } rx_config_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4,
        BREAK = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Flop-chain synchroniser for an asynchronous line that idles high; resets to all ones.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start verification, mid-bit sampling, MSB-first reconstruction,
// one-entry holding register with valid/ack, sticky framing and overrun flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  rx_config_t rx_cfg,
    output logic [8:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    rx_state_t        state, state_n;
    logic             rx_s;
    logic [DIV_W-1:0] cnt, mid_q, end_q;
    logic             word_q, stop_q;
    logic [3:0]       bits_q;
    logic [1:0]       stops_q;
    logic [8:0]       shreg;
    logic             ferr_q;
    logic             at_mid, at_end;
    logic             start_det, data_smp, stop_smp, word_wr, cnt_clr;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    assign at_mid = (cnt == mid_q);
    assign at_end = (cnt == end_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rx_s) state_n = START;
            START:   if (at_mid) state_n = rx_s ? IDLE : DATA;
            DATA:    if (at_end && bits_q == 4'd1) state_n = STOP;
            STOP:    if (at_end && stops_q == 2'd1) state_n = DONE;
            DONE:    state_n = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // After the START mid-sample the counter restarts, so every later "end" is a bit centre.
    always_comb begin
        busy      = (state != IDLE);
        start_det = (state == IDLE) && !rx_s;
        data_smp  = (state == DATA) && at_end;
        stop_smp  = (state == STOP) && at_end;
        word_wr   = (state == DONE);
        cnt_clr   = (state == IDLE) || ((state == START) && at_mid) || at_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            mid_q       <= '0;
            end_q       <= '0;
            word_q      <= 1'b0;
            stop_q      <= 1'b0;
            bits_q      <= 4'd0;
            stops_q     <= 2'd0;
            shreg       <= 9'd0;
            ferr_q      <= 1'b0;
            data        <= 9'd0;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;

            if (start_det) begin
                mid_q  <= (rx_cfg.br_div >> 1) - 1'b1;
                end_q  <= rx_cfg.br_div - 1'b1;
                word_q <= rx_cfg.word;
                stop_q <= rx_cfg.stop;
                bits_q <= rx_cfg.word ? 4'd9 : 4'd8;
                shreg  <= 9'd0;
                ferr_q <= 1'b0;
            end

            if (data_smp) begin
                shreg  <= {shreg[7:0], rx_s};
                bits_q <= bits_q - 4'd1;
                if (bits_q == 4'd1) begin
                    stops_q <= stop_q ? 2'd2 : 2'd1;
                end
            end

            if (stop_smp) begin
                if (!rx_s) begin
                    ferr_q <= 1'b1;
                end
                stops_q <= stops_q - 2'd1;
            end

            // A new word always lands; an unacknowledged old word is lost and flagged.
            if (word_wr) begin
                data        <= word_q ? shreg : {1'b0, shreg[7:0]};
                framing_err <= ferr_q;
                valid       <= 1'b1;
                if (valid && !ack) begin
                    overrun <= 1'b1;
                end else if (valid && ack) begin
                    overrun <= 1'b0;
                end
            end else if (valid && ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: a line driver builds frames bit by bit, a monitor pops
// expected {framing_err, data} words from a queue whenever the receiver presents one.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic       clk;
    logic       rst;
    logic       rx_in;
    rx_config_t cfg;
    logic [8:0] data;
    logic       valid;
    logic       ack;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    logic [9:0] exp_q[$];
    int         vectors;
    int         miscompares;
    bit         auto_ack;
    int         ack_reqs;
    int         ack_done;

    uart_rx #(.SYNC_STAGES(2), .DIV_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_cfg      (cfg),
        .data        (data),
        .valid       (valid),
        .ack         (ack),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected %0d words still queued", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: owns ack. Pops one expected word per presented word when auto_ack is on.
    initial begin
        logic [9:0] e;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack) begin
                ack = 1'b0;
            end else if (ack_done < ack_reqs) begin
                ack = 1'b1;
                ack_done++;
            end else if (auto_ack && valid && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {9'd0, valid}, 10'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {framing_err, data}, e);
                    check("no_overrun", {9'd0, overrun}, 10'd0);
                end
                ack = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int div);
        rx_in = b;
        repeat (div) @(posedge clk);
        #1;
    endtask

    // Reference: the word the receiver must present for a given frame.
    function automatic logic [9:0] model(input logic [8:0] d, input bit w, input bit bad);
        logic [8:0] v;
        v = w ? d : {1'b0, d[7:0]};
        return {bad, v};
    endfunction

    // Drives a full frame (MSB first). bad forces the first stop bit low; lat checks
    // valid timing around the last stop bit centre; abort_bit>=0 pulses rst mid that data bit.
    task automatic send_frame(input logic [8:0] d, input int div, input bit w, input bit s,
                              input bit bad, input bit lat, input int abort_bit);
        int  nbits;
        int  nstops;
        int  seen_at;
        logic b;
        cfg.br_div = div[15:0];
        cfg.word   = w;
        cfg.stop   = s;
        nbits  = w ? 9 : 8;
        nstops = s ? 2 : 1;
        drive_bit(1'b0, div);
        for (int k = 0; k < nbits; k++) begin
            b = d[nbits-1-k];
            if (k == abort_bit) begin
                rx_in = b;
                repeat (div / 2) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                check("abort_busy", {9'd0, busy}, 10'd0);
                check("abort_valid", {9'd0, valid}, 10'd0);
                rx_in = 1'b1;
                return;
            end
            drive_bit(b, div);
        end
        for (int j = 0; j < nstops; j++) begin
            b = (bad && j == 0) ? 1'b0 : 1'b1;
            if (lat && j == nstops - 1) begin
                rx_in = b;
                repeat (div / 2) @(posedge clk);
                #1;
                check("lat_not_early", {9'd0, valid}, 10'd0);
                seen_at = -1;
                for (int c = 1; c <= div - div / 2; c++) begin
                    @(posedge clk);
                    #1;
                    if (valid && seen_at < 0) seen_at = c;
                end
                check("lat_seen", {9'd0, seen_at > 0}, 10'd1);
                check("lat_bound", {9'd0, seen_at <= 6}, 10'd1);
            end else begin
                drive_bit(b, div);
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, exp_q.size(), 10'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0] d;
        int         div;
        bit         w;
        bit         s;
        bit         bad;
        int         i;

        vectors     = 0;
        miscompares = 0;
        auto_ack    = 1'b0;
        ack_reqs    = 0;
        ack_done    = 0;
        rst         = 1'b1;
        rx_in       = 1'b1;
        cfg         = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_data", {1'b0, data}, 10'd0);
        check("rst_valid", {9'd0, valid}, 10'd0);
        check("rst_ferr", {9'd0, framing_err}, 10'd0);
        check("rst_overrun", {9'd0, overrun}, 10'd0);
        check("rst_busy", {9'd0, busy}, 10'd0);
        idle(4);

        // 8N1 at br_div=16 with valid timing around the stop bit centre.
        exp_q.push_back(model(9'h0A5, 1'b0, 1'b0));
        send_frame(9'h0A5, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        auto_ack = 1'b1;
        drain("drain_a5");
        idle(8);

        // 9-bit, two stops, back to back.
        exp_q.push_back(model(9'h1C3, 1'b1, 1'b0));
        send_frame(9'h1C3, 16, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        exp_q.push_back(model(9'h1C3, 1'b1, 1'b0));
        send_frame(9'h1C3, 16, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        drain("drain_1c3");
        idle(8);

        // Short low glitch must be rejected at the start-bit centre.
        cfg.br_div = 16'd16; cfg.word = 1'b0; cfg.stop = 1'b0;
        rx_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("glitch_busy", {9'd0, busy}, 10'd1);
        rx_in = 1'b1;
        for (i = 0; i < 8 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("glitch_idle", {9'd0, busy}, 10'd0);
        idle(40);

        // Bad stop then line held low: one word with framing error, no retrigger.
        exp_q.push_back(model(9'h055, 1'b0, 1'b1));
        send_frame(9'h055, 16, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        rx_in = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("break_busy", {9'd0, busy}, 10'd1);
        check("break_word", exp_q.size(), 10'd0);
        rx_in = 1'b1;
        for (i = 0; i < 6 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("break_release", {9'd0, busy}, 10'd0);
        idle(60);

        // Overrun: two words without ack, then a single ack clears everything.
        auto_ack = 1'b0;
        send_frame(9'h011, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(16);
        send_frame(9'h022, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(16);
        check("ovr_word", {framing_err, data}, model(9'h022, 1'b0, 1'b0));
        check("ovr_flag", {9'd0, overrun}, 10'd1);
        check("ovr_valid", {9'd0, valid}, 10'd1);
        ack_reqs++;
        repeat (3) @(posedge clk);
        #1;
        check("ovr_ack_valid", {9'd0, valid}, 10'd0);
        check("ovr_ack_flag", {9'd0, overrun}, 10'd0);
        auto_ack = 1'b1;
        idle(8);

        // Reset in the middle of data bit 3, then a clean frame.
        send_frame(9'h03C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        idle(40);
        exp_q.push_back(model(9'h03C, 1'b0, 1'b0));
        send_frame(9'h03C, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        drain("drain_3c");
        idle(8);

        // Random frames across formats and divisors.
        for (int n = 0; n < 24; n++) begin
            d   = 9'($urandom_range(0, 511));
            div = $urandom_range(4, 24);
            w   = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 5) == 0);
            exp_q.push_back(model(d, w, bad));
            send_frame(d, div, w, s, bad, 1'b0, -1);
            idle($urandom_range(1, div));
        end
        drain("drain_random");
        idle(40);
        check("final_idle", {8'd0, busy, valid}, 10'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
